// File: rtl/game_timer_bcd_pkg.sv
// Shared encodings and constants for the BCD game timer.
// bcd_of_int turns an integer into a packed BCD vector at elaboration time.
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE   = 4'd9;
    localparam logic [3:0] BCD_ZERO   = 4'd0;
    localparam int         MAX_DIGITS = 6;

    function automatic logic [4*MAX_DIGITS-1:0] bcd_of_int(input int unsigned value,
                                                           input int unsigned digits);
        logic [4*MAX_DIGITS-1:0] res;
        int unsigned             v;
        res = '0;
        v   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < int'(digits)) begin
                res[4*i +: 4] = 4'(v % 32'd10);
                v             = v / 32'd10;
            end else begin
                res[4*i +: 4] = BCD_ZERO;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/game_timer_bcd_if.sv
// Control/status bundle between the game FSM (master) and the timer (slave).
interface game_timer_bcd_if #(
    parameter int DIGITS = 3
);
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_bcd;
    logic                  mode_down;
    logic                  run;
    logic                  freeze;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  tick;
    logic                  done;
    logic                  expired;
    logic                  busy;

    modport master (
        output clr, load, load_bcd, mode_down, run, freeze,
        input  bcd_out, tick, done, expired, busy
    );

    modport slave (
        input  clr, load, load_bcd, mode_down, run, freeze,
        output bcd_out, tick, done, expired, busy
    );
endinterface

// File: rtl/game_timer_bcd_digit.sv
// One BCD decade: counts up or down when enabled and carried into, or loads.
// carry_out is combinational so a full ripple settles within one cycle.
module bcd_digit
    import game_timer_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       carry_in,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       carry_out
);

    // Pass the carry/borrow on when this decade sits at its wrap point
    always_comb begin
        if (dir) begin
            carry_out = carry_in && (q == BCD_ZERO);
        end else begin
            carry_out = carry_in && (q == BCD_NINE);
        end
    end

    // Decade register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= load_val;
        end else if (en && carry_in) begin
            if (dir) begin
                q <= (q == BCD_ZERO) ? BCD_NINE : q - 4'd1;
            end else begin
                q <= (q == BCD_NINE) ? BCD_ZERO : q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_timer_bcd.sv
// N-digit BCD game timer: 1 s prescaler, up/down count, pause/freeze,
// preload, countdown expiry and sticky terminal flag.
module game_timer_bcd
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIGITS   = 3,
    parameter int PRESET   = 0
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    game_timer_bcd_if.slave    bus
);

    localparam int          W          = 4 * DIGITS;
    localparam int          PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  PRESET_BCD = W'(bcd_of_int(PRESET, DIGITS));

    state_t          state_r, state_n;
    logic [PW-1:0]   presc_r, presc_n;
    logic            mode_r, mode_n;
    logic            done_r, done_n;
    logic            tick_r, tick_n;
    logic            expired_r, expired_n;
    logic            busy_r;

    logic            step_s;
    logic            dig_load_s;
    logic [W-1:0]    load_vec_s;
    logic [W-1:0]    clamp_s;
    logic [W-1:0]    value_s;
    logic [DIGITS:0] carry_s;
    logic            term_s;
    logic            upper_term_s;
    logic            near_last_s;

    // With carry_s[0] tied high the chain reports "all digits at terminal"
    assign carry_s[0] = 1'b1;
    assign term_s     = carry_s[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .en        (step_s),
            .dir       (mode_r),
            .carry_in  (carry_s[g]),
            .load      (dig_load_s),
            .load_val  (load_vec_s[4*g +: 4]),
            .q         (value_s[4*g +: 4]),
            .carry_out (carry_s[g+1])
        );
    end

    // Clamp preload nibbles and detect "one step from terminal"
    always_comb begin
        clamp_s      = '0;
        upper_term_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.load_bcd[4*k +: 4] > BCD_NINE) begin
                clamp_s[4*k +: 4] = BCD_NINE;
            end else begin
                clamp_s[4*k +: 4] = bus.load_bcd[4*k +: 4];
            end
        end
        for (int k = 1; k < DIGITS; k++) begin
            if (value_s[4*k +: 4] != (mode_r ? BCD_ZERO : BCD_NINE)) begin
                upper_term_s = 1'b0;
            end else begin
                upper_term_s = upper_term_s;
            end
        end
        near_last_s = upper_term_s && (value_s[3:0] == (mode_r ? 4'd1 : 4'd8));
    end

    // Next-state, prescaler and flag logic; clr > load > freeze > run
    always_comb begin
        state_n    = state_r;
        presc_n    = presc_r;
        mode_n     = mode_r;
        done_n     = done_r;
        tick_n     = 1'b0;
        expired_n  = 1'b0;
        step_s     = 1'b0;
        dig_load_s = 1'b0;
        load_vec_s = clamp_s;
        if (bus.clr) begin
            dig_load_s = 1'b1;
            load_vec_s = bus.mode_down ? PRESET_BCD : '0;
            presc_n    = '0;
            done_n     = 1'b0;
            mode_n     = bus.mode_down;
            state_n    = ST_IDLE;
        end else if (bus.load) begin
            dig_load_s = 1'b1;
            presc_n    = '0;
            done_n     = 1'b0;
            mode_n     = bus.mode_down;
            state_n    = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_n = '0;
                    mode_n  = bus.mode_down;
                    if (bus.run && !bus.freeze && !done_r) begin
                        state_n = ST_RUN;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!bus.run || bus.freeze) begin
                        state_n = ST_PAUSE;
                    end else if (mode_r && term_s) begin
                        // Countdown started from zero: expire without stepping
                        state_n   = ST_DONE;
                        done_n    = 1'b1;
                        expired_n = 1'b1;
                    end else if (presc_r == PRESC_LAST) begin
                        presc_n = '0;
                        if (term_s) begin
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                        end else begin
                            step_s = 1'b1;
                            tick_n = 1'b1;
                            if (near_last_s) begin
                                state_n   = ST_DONE;
                                done_n    = 1'b1;
                                expired_n = mode_r;
                            end else begin
                                state_n = ST_RUN;
                            end
                        end
                    end else begin
                        presc_n = presc_r + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (bus.run && !bus.freeze) begin
                        state_n = ST_RUN;
                    end else begin
                        state_n = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Control and flag registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= ST_IDLE;
            presc_r   <= '0;
            mode_r    <= 1'b0;
            done_r    <= 1'b0;
            tick_r    <= 1'b0;
            expired_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            presc_r   <= presc_n;
            mode_r    <= mode_n;
            done_r    <= done_n;
            tick_r    <= tick_n;
            expired_r <= expired_n;
            busy_r    <= (state_n == ST_RUN);
        end
    end

    assign bus.bcd_out = value_s;
    assign bus.tick    = tick_r;
    assign bus.done    = done_r;
    assign bus.expired = expired_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_game_timer_bcd.sv
// Directed bench for game_timer_bcd with TICK_DIV=4, DIGITS=3, PRESET=10.
module tb_game_timer_bcd;

    logic sys_clk;
    logic sys_rst_n;
    int   errors   = 0;
    int   checks   = 0;
    int   tick_cnt = 0;
    int   exp_cnt  = 0;
    int   snap;

    game_timer_bcd_if #(.DIGITS(3)) bus ();

    game_timer_bcd #(
        .TICK_DIV (4),
        .DIGITS   (3),
        .PRESET   (10)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        #1;
        if (bus.tick === 1'b1) tick_cnt++;
        if (bus.expired === 1'b1) exp_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst_n     = 1'b0;
        bus.clr       = 1'b0;
        bus.load      = 1'b0;
        bus.load_bcd  = 12'h000;
        bus.mode_down = 1'b0;
        bus.run       = 1'b0;
        bus.freeze    = 1'b0;
        cyc(2);
        chk("rst_bcd", 32'(bus.bcd_out), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_tick", 32'(bus.tick), 32'h0);
        chk("rst_expired", 32'(bus.expired), 32'h0);
        sys_rst_n = 1'b1;
        cyc(1);

        // up count
        bus.run = 1'b1;
        cyc(1); chk("t1_busy", 32'(bus.busy), 32'h1);
        cyc(3); chk("t1_pre_tick", 32'(bus.tick), 32'h0);
        cyc(1); chk("t1_first_tick", 32'(bus.tick), 32'h1);
        chk("t1_first_val", 32'(bus.bcd_out), 32'h001);
        cyc(44);
        chk("t1_val12", 32'(bus.bcd_out), 32'h012);
        chk("t1_tick_cnt", 32'(tick_cnt), 32'd12);
        chk("t1_busy2", 32'(bus.busy), 32'h1);
        chk("t1_done", 32'(bus.done), 32'h0);

        // up saturation
        bus.load = 1'b1; bus.load_bcd = 12'h998;
        cyc(1); chk("t2_load", 32'(bus.bcd_out), 32'h998);
        chk("t2_load_idle", 32'(bus.busy), 32'h0);
        bus.load = 1'b0;
        cyc(4); chk("t2_pre_done", 32'(bus.done), 32'h0);
        chk("t2_pre_val", 32'(bus.bcd_out), 32'h998);
        cyc(1); chk("t2_val999", 32'(bus.bcd_out), 32'h999);
        chk("t2_done", 32'(bus.done), 32'h1);
        chk("t2_last_tick", 32'(bus.tick), 32'h1);
        chk("t2_not_busy", 32'(bus.busy), 32'h0);
        snap = tick_cnt;
        cyc(32); chk("t2_hold", 32'(bus.bcd_out), 32'h999);
        chk("t2_no_tick", 32'(tick_cnt), 32'(snap));
        chk("t2_done_sticky", 32'(bus.done), 32'h1);

        // countdown from PRESET
        bus.run = 1'b0; bus.mode_down = 1'b1; bus.clr = 1'b1;
        cyc(1); chk("t3_preset", 32'(bus.bcd_out), 32'h010);
        chk("t3_done_clr", 32'(bus.done), 32'h0);
        bus.clr = 1'b0; bus.run = 1'b1; snap = exp_cnt;
        cyc(40); chk("t3_val001", 32'(bus.bcd_out), 32'h001);
        chk("t3_no_exp_yet", 32'(bus.expired), 32'h0);
        cyc(1); chk("t3_val000", 32'(bus.bcd_out), 32'h000);
        chk("t3_expired", 32'(bus.expired), 32'h1);
        chk("t3_done", 32'(bus.done), 32'h1);
        chk("t3_tick", 32'(bus.tick), 32'h1);
        cyc(12); chk("t3_no_wrap", 32'(bus.bcd_out), 32'h000);
        chk("t3_exp_once", 32'(exp_cnt - snap), 32'd1);

        // pause and freeze
        bus.run = 1'b0; bus.mode_down = 1'b0; bus.clr = 1'b1;
        cyc(1); bus.clr = 1'b0; bus.run = 1'b1;
        cyc(3); bus.run = 1'b0; snap = tick_cnt;
        cyc(20); chk("t4_pause_val", 32'(bus.bcd_out), 32'h000);
        chk("t4_pause_busy", 32'(bus.busy), 32'h0);
        chk("t4_pause_ticks", 32'(tick_cnt), 32'(snap));
        bus.run = 1'b1;
        cyc(2); chk("t4_resume_wait", 32'(bus.tick), 32'h0);
        chk("t4_resume_busy", 32'(bus.busy), 32'h1);
        cyc(1); chk("t4_resume_tick", 32'(bus.tick), 32'h1);
        chk("t4_resume_val", 32'(bus.bcd_out), 32'h001);
        cyc(2); bus.freeze = 1'b1;
        cyc(20); chk("t4_freeze_val", 32'(bus.bcd_out), 32'h001);
        chk("t4_freeze_busy", 32'(bus.busy), 32'h0);
        bus.freeze = 1'b0;
        cyc(2); chk("t4_unfreeze_wait", 32'(bus.tick), 32'h0);
        cyc(1); chk("t4_unfreeze_tick", 32'(bus.tick), 32'h1);
        chk("t4_unfreeze_val", 32'(bus.bcd_out), 32'h002);

        // priority, clamp, mid-period reset
        bus.run = 1'b0; bus.clr = 1'b1; bus.load = 1'b1; bus.load_bcd = 12'h5A3;
        cyc(1); chk("t5_clr_wins", 32'(bus.bcd_out), 32'h000);
        bus.clr = 1'b0;
        cyc(1); chk("t5_load_clamp", 32'(bus.bcd_out), 32'h593);
        bus.load = 1'b0; bus.run = 1'b1;
        cyc(5); chk("t5_pre_rst_val", 32'(bus.bcd_out), 32'h594);
        chk("t5_pre_rst_tick", 32'(bus.tick), 32'h1);
        #2; sys_rst_n = 1'b0; #1;
        chk("t5_rst_bcd", 32'(bus.bcd_out), 32'h0);
        chk("t5_rst_busy", 32'(bus.busy), 32'h0);
        chk("t5_rst_tick", 32'(bus.tick), 32'h0);
        chk("t5_rst_done", 32'(bus.done), 32'h0);
        bus.run = 1'b0;
        cyc(1); sys_rst_n = 1'b1;

        // countdown entered at zero expires at once
        bus.mode_down = 1'b1; bus.run = 1'b1; snap = exp_cnt;
        cyc(1); chk("t7_busy", 32'(bus.busy), 32'h1);
        cyc(1); chk("t7_expired", 32'(bus.expired), 32'h1);
        chk("t7_done", 32'(bus.done), 32'h1);
        chk("t7_no_tick", 32'(bus.tick), 32'h0);
        chk("t7_val", 32'(bus.bcd_out), 32'h000);
        cyc(3); chk("t7_exp_once", 32'(exp_cnt - snap), 32'd1);

        // mode_down ignored outside IDLE
        bus.run = 1'b0; bus.mode_down = 1'b0; bus.clr = 1'b1;
        cyc(1); bus.clr = 1'b0; bus.run = 1'b1;
        cyc(5); chk("t6_up_first", 32'(bus.bcd_out), 32'h001);
        bus.mode_down = 1'b1;
        cyc(8); chk("t6_still_up", 32'(bus.bcd_out), 32'h003);
        bus.clr = 1'b1;
        cyc(1); chk("t6_clr_preset", 32'(bus.bcd_out), 32'h010);
        bus.clr = 1'b0;
        cyc(5); chk("t6_now_down", 32'(bus.bcd_out), 32'h009);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
